// File: rtl/scroll_sequencer.sv
// scroll_sequencer: game-flow controller for the two-lane note scroll datapath.
// It produces the datapath mode code and a one-cycle scroll strobe. A
// speed-selected prescaler paces a pre-play countdown and then the song steps.
// The controller also handles pause and abort, and ends the song once every
// note has left the 8-column window.
module scroll_sequencer #(
   parameter int CLK_DIV_BASE    = 16,
   parameter int NUM_STEPS       = 40,
   parameter int COUNTDOWN_TICKS = 3
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   input  logic [1:0] speed,
   output logic [2:0] mode,
   output logic       scroll,
   output logic [5:0] step_cnt,
   output logic [2:0] countdown,
   output logic       busy,
   output logic       done
);

   localparam int PW = $clog2(CLK_DIV_BASE);
   localparam logic [PW-1:0] BASE_MAX  = PW'(CLK_DIV_BASE - 1);
   localparam logic [5:0]    LAST_STEP = 6'(NUM_STEPS - 1);
   localparam logic [2:0]    CD_INIT   = 3'(COUNTDOWN_TICKS);

   // State values double as the datapath mode code.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd2,
      S_LOAD      = 3'd3,
      S_PLAY      = 3'd4,
      S_DONE      = 3'd5,
      S_PAUSE     = 3'd6
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_presc;
   logic [5:0]      r_step;
   logic [2:0]      r_cd;
   logic [1:0]      r_speed;

   logic [PW-1:0]   w_pmax;
   logic            w_wrap;

   // CLK_DIV_BASE is a power of two, so (BASE >> s) - 1 equals (BASE - 1) >> s.
   function automatic logic [PW-1:0] period_max(input logic [1:0] sp);
      return BASE_MAX >> sp;
   endfunction

   assign w_pmax = period_max(r_speed);
   assign w_wrap = (r_presc == w_pmax);

   // All outputs decode from registers only, so they stay glitch-free.
   assign mode      = r_state;
   assign scroll    = (r_state == S_PLAY) && w_wrap;
   assign step_cnt  = r_step;
   assign countdown = r_cd;
   assign busy      = (r_state == S_LOAD) || (r_state == S_COUNTDOWN) ||
                      (r_state == S_PLAY) || (r_state == S_PAUSE);
   assign done      = (r_state == S_DONE);

   // Game-flow FSM with prescaler, step counter and countdown; abort has top priority.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_step  <= '0;
         r_cd    <= '0;
         r_speed <= '0;
      end else if (abort) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_step  <= '0;
         r_cd    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_presc <= '0;
               r_cd    <= '0;
               if (start) begin
                  // The speed is frozen for the whole song from this point.
                  r_state <= S_LOAD;
                  r_speed <= speed;
                  r_step  <= '0;
               end
            end
            S_LOAD: begin
               r_state <= S_COUNTDOWN;
               r_cd    <= CD_INIT;
               r_presc <= '0;
               r_step  <= '0;
            end
            S_COUNTDOWN: begin
               if (w_wrap) begin
                  r_presc <= '0;
                  if (r_cd == 3'd1) begin
                     r_state <= S_PLAY;
                     r_cd    <= '0;
                  end else begin
                     r_cd <= r_cd - 3'd1;
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end
            S_PLAY: begin
               if (w_wrap) begin
                  // The strobe cycle always counts, even if pause arrives with it.
                  r_presc <= '0;
                  r_step  <= r_step + 6'd1;
                  if (r_step == LAST_STEP) begin
                     r_state <= S_DONE;
                  end else if (pause) begin
                     r_state <= S_PAUSE;
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
                  if (pause) begin
                     r_state <= S_PAUSE;
                  end
               end
            end
            S_PAUSE: begin
               // The prescaler and step counter hold until play resumes.
               if (!pause) begin
                  r_state <= S_PLAY;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_presc <= '0;
               r_step  <= '0;
               r_cd    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scroll_sequencer.sv
// Testbench for scroll_sequencer. It uses a vector table, hand-written
// multi-cycle sequences and random stimulus, all checked against an
// elapsed-time reference model.
module tb_scroll_sequencer;

   localparam int CLK_DIV_BASE    = 16;
   localparam int NUM_STEPS       = 40;
   localparam int COUNTDOWN_TICKS = 3;

   logic       clk;
   logic       n_rst;
   logic       start;
   logic       pause;
   logic       abort;
   logic [1:0] speed;
   logic [2:0] mode;
   logic       scroll;
   logic [5:0] step_cnt;
   logic [2:0] countdown;
   logic       busy;
   logic       done;

   scroll_sequencer #(
      .CLK_DIV_BASE   (CLK_DIV_BASE),
      .NUM_STEPS      (NUM_STEPS),
      .COUNTDOWN_TICKS(COUNTDOWN_TICKS)
   ) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (start),
      .pause    (pause),
      .abort    (abort),
      .speed    (speed),
      .mode     (mode),
      .scroll   (scroll),
      .step_cnt (step_cnt),
      .countdown(countdown),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the phase, plus the cycles elapsed in that phase
   // (pauses excluded), plus the period.
   int m_state;
   int m_el;
   int m_P;

   // Bookkeeping for the song-level checks.
   bit track;
   int cur_P;
   int n_strobe, play_cyc, cd_cyc, load_cyc, pause_cyc;

   typedef struct {
      logic       s;
      logic       p;
      logic       a;
      logic [1:0] sp;
      logic [2:0] mode;
      logic       scr;
      logic [5:0] step;
      logic [2:0] cd;
   } vec_t;

   vec_t tbl [21];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_el    = 0;
      m_P     = CLK_DIV_BASE;
   endtask

   task automatic model_step(input logic s, input logic p, input logic a, input logic [1:0] sp);
      if (a) begin
         m_state = 0;
         m_el    = 0;
      end else begin
         case (m_state)
            0, 5: if (s) begin
               m_state = 3;
               m_P     = CLK_DIV_BASE >> sp;
               m_el    = 0;
            end
            3: begin
               m_state = 2;
               m_el    = 0;
            end
            2: begin
               m_el++;
               if (m_el == COUNTDOWN_TICKS * m_P) begin
                  m_state = 4;
                  m_el    = 0;
               end
            end
            4: begin
               if (m_el == NUM_STEPS * m_P - 1) m_state = 5;
               else if (p) m_state = 6;
               m_el++;
            end
            6: if (!p) m_state = 4;
            default: ;
         endcase
      end
   endtask

   task automatic check_all();
      int e_scr, e_step, e_cd, e_busy;
      e_scr  = (m_state == 4 && (m_el % m_P) == m_P - 1) ? 1 : 0;
      e_step = (m_state == 5) ? NUM_STEPS :
               (m_state == 4 || m_state == 6) ? m_el / m_P : 0;
      e_cd   = (m_state == 2) ? COUNTDOWN_TICKS - m_el / m_P : 0;
      e_busy = (m_state == 2 || m_state == 3 || m_state == 4 || m_state == 6) ? 1 : 0;
      chk("model_mode", int'(mode), m_state);
      chk("model_scroll", int'(scroll), e_scr);
      chk("model_step", int'(step_cnt), e_step);
      chk("model_countdown", int'(countdown), e_cd);
      chk("model_busy", int'(busy), e_busy);
      chk("model_done", int'(done), (m_state == 5) ? 1 : 0);
      if (scroll) chk("scroll_implies_play", int'(mode), 4);
      if (track) begin
         if (mode == 3'd3) load_cyc++;
         if (mode == 3'd2) cd_cyc++;
         if (mode == 3'd4) play_cyc++;
         if (mode == 3'd6) pause_cyc++;
         if (scroll) begin
            n_strobe++;
            chk("strobe_position", play_cyc, n_strobe * cur_P);
         end
      end
   endtask

   task automatic tick(input logic s, input logic p, input logic a, input logic [1:0] sp);
      start = s;
      pause = p;
      abort = a;
      speed = sp;
      @(posedge clk);
      model_step(s, p, a, sp);
      #1;
      check_all();
   endtask

   task automatic run_song(input logic [1:0] sp0, input logic [1:0] sp_mid,
                           input int pause_after, input int pause_len);
      int cyc, pcnt;
      logic p;
      track = 1'b1;
      cur_P = CLK_DIV_BASE >> sp0;
      n_strobe = 0; play_cyc = 0; cd_cyc = 0; load_cyc = 0; pause_cyc = 0;
      pcnt = 0;
      tick(1'b1, 1'b0, 1'b0, sp0);
      cyc = 0;
      while (mode != 3'd5 && cyc < 5000) begin
         p = 1'b0;
         if (pause_len > 0 && n_strobe >= pause_after && pcnt < pause_len &&
             (pcnt > 0 || !scroll)) begin
            p = 1'b1;
            pcnt++;
         end
         tick(1'b0, p, 1'b0, sp_mid);
         if (mode == 3'd6) chk("pause_step_hold", int'(step_cnt), pause_after);
         cyc++;
      end
      chk("song_in_budget", (cyc < 5000) ? 1 : 0, 1);
      chk("song_strobes", n_strobe, NUM_STEPS);
      chk("song_play_cycles", play_cyc, NUM_STEPS * cur_P);
      chk("song_countdown_cycles", cd_cyc, COUNTDOWN_TICKS * cur_P);
      chk("song_load_cycles", load_cyc, 1);
      chk("song_pause_cycles", pause_cyc, pause_len);
      chk("song_final_step", int'(step_cnt), NUM_STEPS);
      chk("song_done_flag", int'(done), 1);
      track = 1'b0;
   endtask

   initial begin
      int c, s0;
      logic p_lvl;
      track = 1'b0;
      start = 1'b0; pause = 1'b0; abort = 1'b0; speed = 2'd0;
      n_rst = 1'b0;
      model_reset();

      // Outputs while reset is held.
      #12;
      chk("reset_mode", int'(mode), 0);
      chk("reset_scroll", int'(scroll), 0);
      chk("reset_step", int'(step_cnt), 0);
      chk("reset_countdown", int'(countdown), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      #11 n_rst = 1'b1;

      // Vector table: one row per clock, starting from IDLE with P = 2.
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd3, 3'd3, 1'b0, 6'd0, 3'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd2, 1'b0, 6'd0, 3'd3};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd2, 1'b0, 6'd0, 3'd3};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd2, 1'b0, 6'd0, 3'd2};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd2, 1'b0, 6'd0, 3'd2};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd2, 1'b0, 6'd0, 3'd1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd3, 3'd2, 1'b0, 6'd0, 3'd1};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd4, 1'b0, 6'd0, 3'd0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd4, 1'b1, 6'd0, 3'd0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd4, 1'b0, 6'd1, 3'd0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd4, 1'b1, 6'd1, 3'd0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd3, 3'd4, 1'b0, 6'd2, 3'd0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 2'd3, 3'd6, 1'b0, 6'd2, 3'd0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd3, 3'd6, 1'b0, 6'd2, 3'd0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd4, 1'b1, 6'd2, 3'd0};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 2'd3, 3'd6, 1'b0, 6'd3, 3'd0};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd4, 1'b0, 6'd3, 3'd0};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 1'b0, 6'd0, 3'd0};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 2'd0, 3'd3, 1'b0, 6'd0, 3'd0};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 1'b0, 6'd0, 3'd3};
      tbl[20] = '{1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 6'd0, 3'd0};
      for (int i = 0; i < 21; i++) begin
         tick(tbl[i].s, tbl[i].p, tbl[i].a, tbl[i].sp);
         chk($sformatf("vec%0d_mode", i), int'(mode), int'(tbl[i].mode));
         chk($sformatf("vec%0d_scroll", i), int'(scroll), int'(tbl[i].scr));
         chk($sformatf("vec%0d_step", i), int'(step_cnt), int'(tbl[i].step));
         chk($sformatf("vec%0d_countdown", i), int'(countdown), int'(tbl[i].cd));
      end

      // Full default song at speed 0, then restart from DONE.
      run_song(2'd0, 2'd0, 0, 0);
      tick(1'b1, 1'b0, 1'b0, 2'd0);
      chk("done_restart_mode", int'(mode), 3);
      chk("done_restart_step", int'(step_cnt), 0);
      tick(1'b0, 1'b0, 1'b1, 2'd0);

      // Speed 3 latched at start; the speed input changes to 0 mid-song.
      run_song(2'd3, 2'd0, 0, 0);
      tick(1'b0, 1'b0, 1'b1, 2'd0);

      // Pause for 10 cycles after the 5th strobe.
      run_song(2'd0, 2'd0, 5, 10);
      tick(1'b0, 1'b0, 1'b1, 2'd0);

      // Pause coincident with a strobe at P = 4.
      tick(1'b1, 1'b0, 1'b0, 2'd2);
      c = 0;
      while (!scroll && c < 500) begin
         tick(1'b0, 1'b0, 1'b0, 2'd2);
         c++;
      end
      chk("coinc_reach_strobe", (c < 500) ? 1 : 0, 1);
      s0 = int'(step_cnt);
      tick(1'b0, 1'b1, 1'b0, 2'd2);
      chk("coinc_pause_mode", int'(mode), 6);
      chk("coinc_step_counted", int'(step_cnt), s0 + 1);
      tick(1'b0, 1'b0, 1'b0, 2'd2);
      chk("coinc_resume_mode", int'(mode), 4);
      c = 0;
      while (!scroll && c < 20) begin
         tick(1'b0, 1'b0, 1'b0, 2'd2);
         c++;
      end
      chk("coinc_resume_from_zero", c, 3);
      tick(1'b0, 1'b1, 1'b0, 2'd2);
      tick(1'b0, 1'b1, 1'b1, 2'd2);
      chk("abort_pause_mode", int'(mode), 0);
      chk("abort_pause_step", int'(step_cnt), 0);

      // Asynchronous reset in the middle of PLAY.
      tick(1'b1, 1'b0, 1'b0, 2'd3);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 2'd3);
      chk("pre_reset_play", int'(mode), 4);
      #2 n_rst = 1'b0;
      #1;
      chk("async_reset_mode", int'(mode), 0);
      chk("async_reset_scroll", int'(scroll), 0);
      chk("async_reset_step", int'(step_cnt), 0);
      chk("async_reset_countdown", int'(countdown), 0);
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_done", int'(done), 0);
      model_reset();
      #2 n_rst = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 2'd0);
      chk("post_reset_idle", int'(mode), 0);

      // Random stimulus against the model.
      p_lvl = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 14) == 0) p_lvl = ~p_lvl;
         tick(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0, p_lvl,
              ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/scroll_sequencer.md
Name: scroll_sequencer

Overview:
- Game-flow controller for the two-lane note scroll/display datapath.
- Generates the datapath's 3-bit `mode` code (load, play, hold) and its single-cycle `scroll` strobe.
- Runs a speed-selectable prescaler, a pre-play countdown, pause/abort handling and a step counter that ends the song once every note has scrolled through the 8-column window.
- Sits between the top-level game FSM/buttons and the scroll/display datapath.

Parameters:
- CLK_DIV_BASE, 16: clock cycles per scroll step at speed 0. Power of two, minimum 8.
- NUM_STEPS, 40: scroll steps per song (32 notes + 8 pad columns). Range 1..63.
- COUNTDOWN_TICKS, 3: scroll periods spent in countdown before play. Range 1..7.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  level; begins a song from IDLE or DONE
- pause  in  1  level; holds play while high
- abort  in  1  level; returns to IDLE
- speed  in  2  period select: period P = CLK_DIV_BASE >> speed
- mode  out  3  datapath mode code
- scroll  out  1  one-cycle shift strobe to the datapath
- step_cnt  out  6  scroll steps completed in the current song
- countdown  out  3  countdown ticks remaining (0 outside COUNTDOWN)
- busy  out  1  high in LOAD, COUNTDOWN, PLAY, PAUSE
- done  out  1  high in DONE

Behaviour:
- Clock and reset: one clock, `clk`. Reset `n_rst` is asynchronous, active-low.
- Reset state: state IDLE; prescaler 0; `step_cnt` 0; `countdown` 0.
- Reset outputs: `mode`=0, `scroll`=0, `busy`=0, `done`=0.
- Mode encoding (`mode` is decoded from the state register only):
  - IDLE = 3'd0
  - COUNTDOWN = 3'd2
  - LOAD = 3'd3
  - PLAY = 3'd4
  - DONE = 3'd5
  - PAUSE = 3'd6
- `abort` has top priority. Any state → IDLE at the next edge; prescaler, `step_cnt` and `countdown` cleared.
- IDLE:
  - start=1 → LOAD.
  - `speed` is latched into an internal register at this edge; `speed` changes are ignored until the next start.
- LOAD:
  - Exactly 1 cycle (datapath copies the new notes), then → COUNTDOWN.
  - `countdown` ← COUNTDOWN_TICKS; prescaler ← 0; `step_cnt` ← 0.
- Prescaler:
  - Counts 0..P-1 in COUNTDOWN and PLAY, wraps to 0.
  - Frozen (value held) in PAUSE; 0 in all other states.
- COUNTDOWN:
  - At each prescaler wrap, `countdown` decrements.
  - On the wrap where `countdown`=1, go to PLAY with `countdown` ← 0 and prescaler ← 0.
  - `pause` is ignored in this state.
- PLAY:
  - `scroll` = (state==PLAY && prescaler==P-1). Combinational from registers, glitch-free, exactly 1 cycle wide.
  - `step_cnt` increments at the edge ending each `scroll` cycle.
  - If `step_cnt`==NUM_STEPS-1 at that edge → DONE; a final `scroll` is still issued.
  - Otherwise pause=1 → PAUSE.
  - `start` is ignored.
- Pause in a `scroll` cycle: if `pause` is high during a `scroll` cycle, the step still counts, the prescaler wraps to 0, then → PAUSE.
- PAUSE:
  - `scroll`=0; prescaler and `step_cnt` held.
  - pause=0 → PLAY, prescaler resuming from its held value.
- DONE:
  - `step_cnt` holds NUM_STEPS.
  - start=1 → LOAD, re-latching `speed`.
- Latency from start edge:
  - LOAD lasts 1 cycle.
  - COUNTDOWN lasts COUNTDOWN_TICKS·P cycles.
  - First `scroll` occurs on the P-th cycle of PLAY.
  - PLAY lasts NUM_STEPS·P cycles in total, excluding pauses.
- Invariant: `scroll`=1 implies `mode`=4 in the same cycle. `scroll` is never asserted in any other mode.

Test Plan:
- Reset mid-PLAY (assert n_rst=0 asynchronously) → all outputs 0 immediately, without waiting for a clock edge; state IDLE after release.
- Defaults, speed=0, 1-cycle start pulse:
  - `mode`=3 for 1 cycle.
  - `mode`=2 for 48 cycles, `countdown` stepping 3→2→1.
  - `mode`=4: first `scroll` 16 cycles after PLAY entry, 40 strobes spaced 16 cycles.
  - `mode`=5 with `step_cnt`=40 the cycle after the 40th strobe; `done`=1.
- Speed changes:
  - speed=3 → P=2: strobes every 2nd cycle, 80 PLAY cycles.
  - speed changed to 0 mid-song → spacing stays 2.
- Pause handling:
  - pause high for 10 cycles after the 5th strobe → `mode`=6, no `scroll`, `step_cnt`=5 held.
  - After release, strobe spacing resumes from the held prescaler value; total strobes still 40.
- Pause coincident with a strobe:
  - pause asserted in the same cycle as a `scroll` → that step counts (`step_cnt` +1), then PAUSE with prescaler 0.
  - abort during COUNTDOWN and during PAUSE → IDLE next edge, `step_cnt`=0, `mode`=0.
- Start in PLAY ignored.
- Start in DONE → LOAD (`mode`=3) next cycle, `step_cnt` cleared.
- Invariant check over all runs: `scroll`=1 ⇒ `mode`=4.
